fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares one FIFO write port among NUM_REQ producers on a single clock domain.
//  Round-robin grant, held for a whole burst (until i_req_last or MAX_BURST beats).
//  Drives the FIFO write strobe and data. Sits between producer blocks and a fifo write side.
// PARAMETERS
//  NUM_REQ    4   number of requesters (>=1)
//  WIDTH      8   data width per beat
//  MAX_BURST  16  max beats per grant (>=1); grant released at this count even without last
//  TIMEOUT    64  idle-grant watchdog cycles (used only with FIFO_ARB_TIMEOUT_EN)
// PORTS
//  i_clk         in   1                clock
//  i_rst         in   1                synchronous, active-high reset
//  i_req_stb     in   NUM_REQ          per-requester beat valid
//  i_req_data    in   NUM_REQ*WIDTH    requester k data at [k*WIDTH +: WIDTH]
//  i_req_last    in   NUM_REQ          final beat of requester burst (qualified by stb)
//  o_req_ack     out  NUM_REQ          one-hot, beat accepted this cycle
//  o_grant       out  NUM_REQ          one-hot current owner, 0 when idle
//  o_busy        out  1                grant held (state BURST)
//  o_fifo_stb    out  1                FIFO write strobe
//  o_fifo_data   out  WIDTH            FIFO write data
//  i_fifo_full   in   1                FIFO full flag
//  o_timeout     out  1                1-cycle pulse, watchdog release (option only)
// BEHAVIOUR
//  Reset: state IDLE, o_grant=0, o_busy=0, rr pointer=0, beat count=0, o_timeout=0.
//   Reset overrides everything; an in-flight burst is dropped, no ack in the reset cycle.
//  FSM IDLE: if any i_req_stb, pick first requesting index at or after rr pointer
//   (wrapping mod NUM_REQ); register grant, go BURST next cycle. No transfer in IDLE.
//  FSM BURST: beat = i_req_stb[g] & !i_fifo_full (combinational, same cycle):
//   o_fifo_stb=beat, o_req_ack[g]=beat, o_fifo_data=i_req_data[g]; count++ on beat.
//   Release -> IDLE when beat & (i_req_last[g] | count==MAX_BURST-1); rr pointer<=g+1 mod NUM_REQ.
//   last and MAX_BURST on same beat: single release. Non-granted stb/last ignored.
//  o_fifo_data = 0 when no grant; o_req_ack all 0 when o_fifo_stb=0.
//  Full: no stb/ack, count unchanged, grant held indefinitely; never writes while full.
//  Latency: request->first possible ack = 1 cycle; one IDLE bubble between bursts.
//  Granted requester dropping stb mid-burst: grant held (no release without option).
//  NUM_REQ=1: same FSM, pointer constant 0.
// CONFIGURATION
//  FIFO_ARB_TIMEOUT_EN defined: counter of consecutive BURST cycles with !i_req_stb[g]
//   (full-stall cycles do not count, counter cleared on beat). Reaching TIMEOUT:
//   release to IDLE, rr pointer<=g+1, o_timeout=1 for one cycle.
//  Not defined: no watchdog logic, o_timeout tied 0, grant held until last/MAX_BURST.
// STRUCTURE
//  fifo_arb_pkg: state encodings (ST_IDLE, ST_BURST), clog2-based ID/count widths.
//  Sub-module rr_pick: combinational rotate-priority pick(req vector, pointer) ->
//   one-hot + index + valid; instantiated once in IDLE path.
// TESTING
//  Reset, no req: o_fifo_stb=0, o_grant=0, o_busy=0 for all cycles.
//  Req0 burst 3 beats (A1,A2,A3 last), full=0: grant 1 cycle later, FIFO gets A1..A3 on
//   consecutive cycles, release after A3, o_grant=0 next cycle.
//  All 4 requesting single-beat bursts: grant order 0,1,2,3,0 with one bubble each.
//  Req1 20-beat stream, MAX_BURST=16: release after 16 beats; req2 pending gets grant next.
//  full=1 for 5 cycles mid-burst: no stb/ack, data held; resumes at same beat after full=0.
//  TIMEOUT=8, option on: granted req2 drops stb -> o_timeout pulse after 8 cycles, grant to 3.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Optional watchdog is enabled by defining FIFO_ARB_TIMEOUT_EN.
package fifo_wr_arbiter_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_t;

   // Index/counter width that never collapses to zero bits.
   function automatic int unsigned width_of(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side bundle for the arbiter.
// Handshake: a beat moves when the granted requester's i_req_stb is high and i_fifo_full is low;
// o_req_ack and o_fifo_stb assert in that same cycle, there is no back-pressure other than full.
interface fifo_wr_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 8
);
   logic [NUM_REQ-1:0]       i_req_stb;
   logic [NUM_REQ*WIDTH-1:0] i_req_data;
   logic [NUM_REQ-1:0]       i_req_last;
   logic [NUM_REQ-1:0]       o_req_ack;
   logic                     o_fifo_stb;
   logic [WIDTH-1:0]         o_fifo_data;
   logic                     i_fifo_full;

   modport slave (
      input  i_req_stb, i_req_data, i_req_last, i_fifo_full,
      output o_req_ack, o_fifo_stb, o_fifo_data
   );

   modport master (
      output i_req_stb, i_req_data, i_req_last, i_fifo_full,
      input  o_req_ack, o_fifo_stb, o_fifo_data
   );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or after i_ptr, wrapping modulo NUM_REQ.
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDW     = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDW-1:0]     i_ptr,
   output logic [NUM_REQ-1:0] o_onehot,
   output logic [IDW-1:0]     o_idx,
   output logic               o_valid
);

   int w_k;

   // Scan from the farthest offset down so the nearest request wins.
   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_valid  = 1'b0;
      w_k      = 0;
      for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
         w_k = (int'(i_ptr) + off) % int'(NUM_REQ);
         if (i_req[w_k]) begin
            o_onehot      = '0;
            o_onehot[w_k] = 1'b1;
            o_idx         = IDW'(w_k);
            o_valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_TIMEOUT_EN to add the idle-grant watchdog (o_timeout); otherwise o_timeout is 0.
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_BURST = 16,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic               i_clk,
   input  logic               i_rst,
   fifo_wr_arbiter_if.slave   bus,
   output logic [NUM_REQ-1:0] o_grant,
   output logic               o_busy,
   output logic               o_timeout,
   output arb_state_t         o_dbg_state
);

   localparam int unsigned IDW = width_of(NUM_REQ);
   localparam int unsigned CW  = width_of(MAX_BURST);

   arb_state_t          r_state, w_state_nxt;
   logic [IDW-1:0]      r_idx, r_ptr, w_ptr_after, w_pick_idx;
   logic [NUM_REQ-1:0]  r_grant, w_pick_oh;
   logic [CW-1:0]       r_count;
   logic                w_pick_vld;
   logic                w_gstb, w_glast, w_beat, w_burst_end, w_wd_fire, w_release;
   logic [WIDTH-1:0]    w_gdata;

   rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
      .i_req    (bus.i_req_stb),
      .i_ptr    (r_ptr),
      .o_onehot (w_pick_oh),
      .o_idx    (w_pick_idx),
      .o_valid  (w_pick_vld)
   );

   assign w_gstb  = bus.i_req_stb[r_idx];
   assign w_glast = bus.i_req_last[r_idx];
   assign w_gdata = bus.i_req_data[int'(r_idx)*int'(WIDTH) +: WIDTH];

   // Reset suppresses any transfer in its own cycle, even mid-burst.
   assign w_beat      = (r_state == ST_BURST) & w_gstb & ~bus.i_fifo_full & ~i_rst;
   assign w_burst_end = w_beat & (w_glast | (r_count == CW'(MAX_BURST - 1)));
   assign w_release   = w_burst_end | w_wd_fire;
   assign w_ptr_after = (r_idx == IDW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;

`ifdef FIFO_ARB_TIMEOUT_EN
   localparam int unsigned TW = width_of(TIMEOUT);
   logic [TW-1:0] r_wd;
   logic          w_wd_tick;

   // Only cycles where the owner is silent and the FIFO could accept count as idle.
   assign w_wd_tick = (r_state == ST_BURST) & ~w_gstb & ~bus.i_fifo_full & ~i_rst;
   assign w_wd_fire = w_wd_tick & (r_wd == TW'(TIMEOUT - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst || r_state != ST_BURST || w_beat || w_wd_fire) begin
         r_wd <= '0;
      end else if (w_wd_tick) begin
         r_wd <= r_wd + 1'b1;
      end
   end
`else
   assign w_wd_fire = 1'b0 && (TIMEOUT > 0);
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_pick_vld) w_state_nxt = ST_BURST;
         ST_BURST: if (w_release)  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_ptr   <= '0;
         r_grant <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE) begin
            if (w_pick_vld) begin
               r_idx   <= w_pick_idx;
               r_grant <= w_pick_oh;
               r_count <= '0;
            end
         end else if (w_release) begin
            r_ptr   <= w_ptr_after;
            r_grant <= '0;
            r_count <= '0;
         end else if (w_beat) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign o_grant         = r_grant;
   assign o_busy          = (r_state == ST_BURST);
   assign o_timeout       = w_wd_fire;
   assign o_dbg_state     = r_state;
   assign bus.o_fifo_stb  = w_beat;
   assign bus.o_req_ack   = w_beat ? r_grant : '0;
   assign bus.o_fifo_data = (r_state == ST_BURST) ? w_gdata : '0;

endmodule
